vec_op_pipe: RTL and testbench

//   Parametrised, pipelined vector operation unit with valid/ready handshakes on input and output.

---
 rtl/vec_op_pkg.sv | 18 +
 rtl/vec_op_stage.sv | 28 ++
 rtl/vec_op_pipe.sv | 88 ++++++++
 tb/tb_vec_op_pipe.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_op_pkg.sv
// Opcode encoding and helpers shared by the vector operation pipeline.
package vec_op_pkg;

    typedef enum logic [2:0] {
        OP_XOR = 3'd0,
        OP_INC = 3'd1,
        OP_EQ  = 3'd2,
        OP_NOT = 3'd3,
        OP_ADD = 3'd4
    } op_e;

    localparam op_e OP_LAST = OP_ADD;

    function automatic logic op_legal(input logic [2:0] op);
        return op <= 3'(OP_LAST);
    endfunction

endpackage

// File: rtl/vec_op_stage.sv
// One valid/ready pipeline register; accepts whenever empty or draining this cycle.
module vec_op_stage #(
    parameter type T = logic [7:0]
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data
);

    assign in_ready = ~out_valid | out_ready;

    // Payload only loads on a real transfer so a stalled or idle stage keeps its value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) out_data <= in_data;
        end
    end

endmodule

// File: rtl/vec_op_pipe.sv
// Two-stage vector op unit: stage 1 holds operands, decode sits between, stage 2 holds result.
module vec_op_pipe
    import vec_op_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic             out_zero,
    output logic             out_err,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] op_count
);

    typedef struct packed {
        logic [2:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } s1_t;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             carry;
        logic             zero;
        logic             err;
    } s2_t;

    s1_t            s1_in, s1_q;
    s2_t            s2_in, s2_q;
    logic           s1_valid, s2_ready;
    logic [WIDTH:0] sum;

    assign s1_in = '{op: in_op, a: in_a, b: in_b};

    vec_op_stage #(.T(s1_t)) u_s1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(s1_in),
        .out_valid(s1_valid), .out_ready(s2_ready), .out_data(s1_q)
    );

    // Result is computed one bit wider so INC/ADD expose their carry in sum[WIDTH].
    always_comb begin
        sum = '0;
        case (s1_q.op)
            OP_XOR:  sum = {1'b0, s1_q.a ^ s1_q.b};
            OP_INC:  sum = {1'b0, s1_q.a} + (WIDTH+1)'(1);
            OP_EQ:   sum = (WIDTH+1)'(s1_q.a == s1_q.b);
            OP_NOT:  sum = {1'b0, ~s1_q.a};
            OP_ADD:  sum = {1'b0, s1_q.a} + {1'b0, s1_q.b};
            default: sum = '0;
        endcase
        s2_in.data  = sum[WIDTH-1:0];
        s2_in.carry = sum[WIDTH];
        s2_in.zero  = (sum[WIDTH-1:0] == '0);
        s2_in.err   = ~op_legal(s1_q.op);
    end

    vec_op_stage #(.T(s2_t)) u_s2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s1_valid), .in_ready(s2_ready), .in_data(s2_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(s2_q)
    );

    assign out_data  = s2_q.data;
    assign out_carry = s2_q.carry;
    assign out_zero  = s2_q.zero;
    assign out_err   = s2_q.err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            op_count <= '0;
        else if (clr_cnt)
            op_count <= '0;
        else if (out_valid && out_ready && (op_count != '1))
            op_count <= op_count + CNT_W'(1);
    end

endmodule

// File: tb/tb_vec_op_pipe.sv
// Directed bench for vec_op_pipe: WIDTH=8 main instance plus a CNT_W=2 instance for saturation.
module tb_vec_op_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [2:0]  in_op;
    logic [7:0]  in_a, in_b, out_data;
    logic        out_carry, out_zero, out_err, clr_cnt;
    logic [15:0] op_count;

    logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready;
    logic [2:0]  c_in_op;
    logic [7:0]  c_in_a, c_in_b, c_out_data;
    logic        c_out_carry, c_out_zero, c_out_err, c_clr_cnt;
    logic [1:0]  c_op_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vec_op_pipe #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_carry(out_carry),
        .out_zero(out_zero), .out_err(out_err), .clr_cnt(clr_cnt), .op_count(op_count)
    );

    vec_op_pipe #(.WIDTH(8), .CNT_W(2)) dut_cnt (
        .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_op(c_in_op), .in_a(c_in_a), .in_b(c_in_b), .out_valid(c_out_valid),
        .out_ready(c_out_ready), .out_data(c_out_data), .out_carry(c_out_carry),
        .out_zero(c_out_zero), .out_err(c_out_err), .clr_cnt(c_clr_cnt), .op_count(c_op_count)
    );

    task automatic idle(input int n);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sends one beat into an empty pipe; mid_valid is out_valid between the two edges.
    task automatic drive_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                            output logic mid_valid);
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        mid_valid = out_valid;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_carry !== 1'b0 ||
            out_zero !== 1'b0 || out_err !== 1'b0 || op_count !== 16'h0) begin
            errors++;
            $display("FAIL reset_state: valid=%b data=%h c=%b z=%b e=%b cnt=%0d, want all 0",
                     out_valid, out_data, out_carry, out_zero, out_err, op_count);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_xor();
        logic mid;
        drive_op(3'd0, 8'hA5, 8'h0F, mid);
        checks++;
        if (mid !== 1'b0) begin
            errors++; $display("FAIL xor_latency_early: out_valid=%b after 1 edge want 0", mid);
        end
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hAA || out_carry !== 1'b0 || out_zero !== 1'b0) begin
            errors++;
            $display("FAIL xor_result: valid=%b data=%h c=%b z=%b want 1 aa 0 0",
                     out_valid, out_data, out_carry, out_zero);
        end
        idle(2);
    endtask

    task automatic test_arith();
        logic mid;
        drive_op(3'd1, 8'hFF, 8'h00, mid);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h00 || out_carry !== 1'b1 || out_zero !== 1'b1) begin
            errors++;
            $display("FAIL inc_wrap: valid=%b data=%h c=%b z=%b want 1 00 1 1",
                     out_valid, out_data, out_carry, out_zero);
        end
        drive_op(3'd4, 8'h80, 8'h80, mid);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h00 || out_carry !== 1'b1 || out_zero !== 1'b1) begin
            errors++;
            $display("FAIL add_carry: valid=%b data=%h c=%b z=%b want 1 00 1 1",
                     out_valid, out_data, out_carry, out_zero);
        end
        drive_op(3'd4, 8'h12, 8'h34, mid);
        checks++;
        if (out_data !== 8'h46 || out_carry !== 1'b0 || out_err !== 1'b0) begin
            errors++;
            $display("FAIL add_plain: data=%h c=%b e=%b want 46 0 0", out_data, out_carry, out_err);
        end
        idle(2);
    endtask

    task automatic test_logic_err();
        logic mid;
        drive_op(3'd2, 8'h3C, 8'h3C, mid);
        checks++;
        if (out_data !== 8'h01 || out_carry !== 1'b0 || out_zero !== 1'b0) begin
            errors++; $display("FAIL eq_match: data=%h c=%b z=%b want 01 0 0", out_data, out_carry, out_zero);
        end
        drive_op(3'd2, 8'h3C, 8'h3D, mid);
        checks++;
        if (out_data !== 8'h00 || out_zero !== 1'b1) begin
            errors++; $display("FAIL eq_miss: data=%h z=%b want 00 1", out_data, out_zero);
        end
        drive_op(3'd3, 8'h00, 8'h55, mid);
        checks++;
        if (out_data !== 8'hFF || out_carry !== 1'b0 || out_zero !== 1'b0 || out_err !== 1'b0) begin
            errors++; $display("FAIL not_zero: data=%h c=%b z=%b e=%b want ff 0 0 0",
                               out_data, out_carry, out_zero, out_err);
        end
        drive_op(3'd6, 8'h12, 8'h34, mid);
        checks++;
        if (out_data !== 8'h00 || out_carry !== 1'b0 || out_zero !== 1'b1 || out_err !== 1'b1) begin
            errors++; $display("FAIL illegal_op: data=%h c=%b z=%b e=%b want 00 0 1 1",
                               out_data, out_carry, out_zero, out_err);
        end
        idle(2);
    endtask

    task automatic test_backpressure();
        logic [7:0]  av [5];
        logic [7:0]  ev [5];
        logic [7:0]  hd;
        logic [15:0] cnt0;
        logic        held;
        int          sent, recv;
        av = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
        ev = '{8'h11, 8'h21, 8'h31, 8'h41, 8'h51};
        sent = 0; recv = 0; held = 1'b0; hd = 8'h00; cnt0 = op_count;
        for (int c = 0; c < 40 && recv < 5; c++) begin
            out_ready = (c >= 3);
            in_valid  = (sent < 5);
            in_op     = 3'd0;
            in_a      = av[(sent < 5) ? sent : 4];
            in_b      = 8'h01;
            #1;
            if (c == 2) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++; $display("FAIL bp_full_ready: in_ready=%b want 0", in_ready);
                end
            end
            if (held) begin
                checks++;
                if (out_data !== hd) begin
                    errors++; $display("FAIL bp_hold_stable: data=%h want %h", out_data, hd);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (recv >= 5 || out_data !== ev[(recv < 5) ? recv : 4]) begin
                    errors++; $display("FAIL bp_order: beat %0d data=%h want %h",
                                       recv, out_data, ev[(recv < 5) ? recv : 4]);
                end
                recv++;
            end
            held = out_valid && !out_ready;
            hd   = out_data;
            if (in_valid && in_ready) sent++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        checks++;
        if (recv != 5 || sent != 5) begin
            errors++; $display("FAIL bp_count: sent=%0d recv=%0d want 5 5", sent, recv);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL bp_no_dup: out_valid=%b want 0", out_valid);
        end
        checks++;
        if (op_count !== cnt0 + 16'd5) begin
            errors++; $display("FAIL bp_op_count: got %0d want %0d", op_count, cnt0 + 16'd5);
        end
    endtask

    task automatic test_reset_flight();
        logic seen;
        out_ready = 1'b0;
        in_valid = 1'b1; in_op = 3'd3; in_a = 8'h0F; in_b = 8'h00;
        @(posedge clk); #1;
        in_a = 8'hF0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_err !== 1'b0 || op_count !== 16'h0) begin
            errors++; $display("FAIL rst_flight_clear: valid=%b data=%h e=%b cnt=%0d want 0 00 0 0",
                               out_valid, out_data, out_err, op_count);
        end
        @(posedge clk);
        #3 rst_n = 1'b1;
        out_ready = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL rst_flight_stale: stale beat seen=%b want 0", seen);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL rst_flight_ready: in_ready=%b want 1", in_ready);
        end
    endtask

    task automatic test_counter_sat();
        int wait_cyc;
        c_out_ready = 1'b1; c_in_op = 3'd0; c_in_a = 8'h01; c_in_b = 8'h02;
        c_in_valid = 1'b1;
        repeat (4) @(posedge clk);
        #1 c_in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (c_op_count !== 2'd3) begin
            errors++; $display("FAIL cnt_saturate: got %0d want 3", c_op_count);
        end
        c_in_valid = 1'b1;
        @(posedge clk); #1;
        c_in_valid = 1'b0;
        wait_cyc = 0;
        while (!c_out_valid && wait_cyc < 10) begin
            @(posedge clk); #1;
            wait_cyc++;
        end
        checks++;
        if (c_out_valid !== 1'b1) begin
            errors++; $display("FAIL cnt_wait_valid: timed out, out_valid=%b want 1", c_out_valid);
        end
        c_clr_cnt = 1'b1;
        @(posedge clk); #1;
        c_clr_cnt = 1'b0;
        checks++;
        if (c_op_count !== 2'd0 || c_out_valid !== 1'b0) begin
            errors++; $display("FAIL cnt_clear_wins: cnt=%0d valid=%b want 0 0", c_op_count, c_out_valid);
        end
    endtask

    initial begin
        in_valid = 1'b0; in_op = 3'd0; in_a = 8'h00; in_b = 8'h00;
        out_ready = 1'b1; clr_cnt = 1'b0;
        c_in_valid = 1'b0; c_in_op = 3'd0; c_in_a = 8'h00; c_in_b = 8'h00;
        c_out_ready = 1'b1; c_clr_cnt = 1'b0;
        test_reset();
        test_xor();
        test_arith();
        test_logic_err();
        test_backpressure();
        test_reset_flight();
        test_counter_sat();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
